// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID pipeline register. Captures instruction bytes from
// fetch, assembles two-byte (opcode 12) instructions with their immediate,
// feeds the last first-byte opcode/brx back to fetch control, and tags the
// first instruction completed after an accepted interrupt.
module fetch_decode_reg #(
  parameter int          PC_W = 8,
  parameter logic [7:0]  NOP  = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            fetch_valid,
  input  logic            hold,
  input  logic            flush,
  input  logic            int_in,
  output logic            ifid_valid,
  output logic [7:0]      ifid_instr,
  output logic [7:0]      ifid_imm,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_int,
  output logic [3:0]      fb_opcode,
  output logic [1:0]      fb_brx,
  output logic            imm_pending
);

  typedef enum logic {S_ONE = 1'b0, S_IMM = 1'b1} state_t;

  localparam logic [3:0] OP_TWO_BYTE = 4'd12;

  state_t            state_q, state_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [7:0]        ifid_instr_q, ifid_instr_d;
  logic [7:0]        ifid_imm_q, ifid_imm_d;
  logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic              ifid_int_q, ifid_int_d;
  logic [3:0]        fb_opcode_q, fb_opcode_d;
  logic [1:0]        fb_brx_q, fb_brx_d;
  logic [7:0]        stage_instr_q, stage_instr_d;
  logic [PC_W-1:0]   stage_pc_q, stage_pc_d;
  logic              int_pend_q, int_pend_d;

  logic accept;
  logic completes;

  assign accept = fetch_valid & ~hold & ~flush;

  // Next-state and datapath: flush > hold > accept > bubble.
  always_comb begin
    state_d       = state_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_imm_d    = ifid_imm_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_int_d    = ifid_int_q;
    fb_opcode_d   = fb_opcode_q;
    fb_brx_d      = fb_brx_q;
    stage_instr_d = stage_instr_q;
    stage_pc_d    = stage_pc_q;
    completes     = 1'b0;

    if (flush) begin
      state_d       = S_ONE;
      ifid_valid_d  = 1'b0;
      ifid_instr_d  = NOP;
      ifid_int_d    = 1'b0;
      fb_opcode_d   = 4'd0;
      fb_brx_d      = 2'd0;
      stage_instr_d = NOP;
      stage_pc_d    = '0;
    end else if (hold) begin
      // everything frozen
    end else if (accept) begin
      if (state_q == S_IMM) begin
        // Immediate byte closes the staged two-byte instruction. fb_* go to
        // zero so fetch control does not take the second-byte path again.
        completes    = 1'b1;
        ifid_instr_d = stage_instr_q;
        ifid_pc_d    = stage_pc_q;
        ifid_imm_d   = instr_in;
        ifid_valid_d = 1'b1;
        fb_opcode_d  = 4'd0;
        fb_brx_d     = 2'd0;
        state_d      = S_ONE;
      end else if (instr_in[7:4] == OP_TWO_BYTE) begin
        stage_instr_d = instr_in;
        stage_pc_d    = pc_in;
        ifid_valid_d  = 1'b0;
        ifid_int_d    = 1'b0;
        fb_opcode_d   = instr_in[7:4];
        fb_brx_d      = instr_in[3:2];
        state_d       = S_IMM;
      end else begin
        completes    = 1'b1;
        ifid_instr_d = instr_in;
        ifid_pc_d    = pc_in;
        ifid_imm_d   = 8'h00;
        ifid_valid_d = 1'b1;
        fb_opcode_d  = instr_in[7:4];
        fb_brx_d     = instr_in[3:2];
      end
      if (completes) begin
        ifid_int_d = int_pend_q | int_in;
      end
    end else begin
      // Bubble: nothing fetched; S_IMM keeps waiting with staging intact.
      ifid_valid_d = 1'b0;
      ifid_int_d   = 1'b0;
      fb_opcode_d  = 4'd0;
      fb_brx_d     = 2'd0;
    end
  end

  // Interrupt pending: set by int_in unless this edge completes an
  // instruction (tag goes straight out); survives hold and flush so a
  // redirect cannot lose the interrupt tag.
  always_comb begin
    int_pend_d = int_pend_q;
    if (completes) begin
      int_pend_d = 1'b0;
    end else if (int_in) begin
      int_pend_d = 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_ONE;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= NOP;
      ifid_imm_q    <= 8'h00;
      ifid_pc_q     <= '0;
      ifid_int_q    <= 1'b0;
      fb_opcode_q   <= 4'd0;
      fb_brx_q      <= 2'd0;
      stage_instr_q <= NOP;
      stage_pc_q    <= '0;
      int_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_imm_q    <= ifid_imm_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_int_q    <= ifid_int_d;
      fb_opcode_q   <= fb_opcode_d;
      fb_brx_q      <= fb_brx_d;
      stage_instr_q <= stage_instr_d;
      stage_pc_q    <= stage_pc_d;
      int_pend_q    <= int_pend_d;
    end
  end

  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_imm    = ifid_imm_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_int    = ifid_int_q;
  assign fb_opcode   = fb_opcode_q;
  assign fb_brx      = fb_brx_q;
  assign imm_pending = (state_q == S_IMM);

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed scenario tests for the IF/ID register.
module tb_fetch_decode_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr_in;
  logic [7:0] pc_in;
  logic       fetch_valid, hold, flush, int_in;
  logic       ifid_valid;
  logic [7:0] ifid_instr, ifid_imm, ifid_pc;
  logic       ifid_int;
  logic [3:0] fb_opcode;
  logic [1:0] fb_brx;
  logic       imm_pending;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_decode_reg #(.PC_W(8), .NOP(8'h00)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .fetch_valid(fetch_valid), .hold(hold), .flush(flush), .int_in(int_in),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_imm(ifid_imm),
    .ifid_pc(ifid_pc), .ifid_int(ifid_int), .fb_opcode(fb_opcode),
    .fb_brx(fb_brx), .imm_pending(imm_pending)
  );

  always #5 clk = ~clk;

  // One clock edge, then sample 1 time unit later; one line per transaction.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t in=%h pc=%h fv=%b h=%b fl=%b int=%b -> v=%b instr=%h imm=%h pc=%h int=%b fb=%0d/%0d ip=%b",
             $time, instr_in, pc_in, fetch_valid, hold, flush, int_in,
             ifid_valid, ifid_instr, ifid_imm, ifid_pc, ifid_int,
             fb_opcode, fb_brx, imm_pending);
  endtask

  task automatic drive(input logic fv, input logic [7:0] ins, input logic [7:0] pc);
    fetch_valid = fv;
    instr_in    = ins;
    pc_in       = pc;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    reset = 1'b0; hold = 0; flush = 0; int_in = 0;
    drive(1'b1, 8'hB5, 8'h01);
    step(); step();
    exp = {1'b0, 8'h00, 4'd0, 1'b0};
    total_cnt++;
    if ({ifid_valid, ifid_instr, fb_opcode, imm_pending} !== exp)
      $display("FAIL reset: got %h required %h", {ifid_valid, ifid_instr, fb_opcode, imm_pending}, exp);
    else pass_cnt++;
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_one_byte();
    logic [7:0] ins [3] = '{8'h15, 8'h26, 8'hB4};
    logic [3:0] ops [3] = '{4'd1, 4'd2, 4'd11};
    logic [1:0] brx [3] = '{2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 8'(3 + i));
      step();
      total_cnt++;
      if ({ifid_valid, ifid_instr, ifid_pc, ifid_imm, fb_opcode, fb_brx} !==
          {1'b1, ins[i], 8'(3 + i), 8'h00, ops[i], brx[i]})
        $display("FAIL one_byte[%0d]: got v=%b instr=%h pc=%h imm=%h fb=%0d/%0d required instr=%h pc=%h fb=%0d/%0d",
                 i, ifid_valid, ifid_instr, ifid_pc, ifid_imm, fb_opcode, fb_brx,
                 ins[i], 8'(3 + i), ops[i], brx[i]);
      else pass_cnt++;
    end
    drive(1'b0, 8'h00, 8'h00);
    step();
    total_cnt++;
    if (ifid_valid !== 1'b0) $display("FAIL one_byte_bubble: got v=%b required 0", ifid_valid);
    else pass_cnt++;
  endtask

  task automatic test_two_byte();
    drive(1'b1, 8'hC1, 8'h07);
    step();
    total_cnt++;
    if ({ifid_valid, imm_pending, fb_opcode, fb_brx} !== {1'b0, 1'b1, 4'd12, 2'd0})
      $display("FAIL two_byte_first: got v=%b ip=%b fb=%0d/%0d required v=0 ip=1 fb=12/0",
               ifid_valid, imm_pending, fb_opcode, fb_brx);
    else pass_cnt++;
    drive(1'b0, 8'h99, 8'h08);
    step();
    total_cnt++;
    if ({ifid_valid, imm_pending} !== 2'b01)
      $display("FAIL two_byte_gap: got v=%b ip=%b required v=0 ip=1", ifid_valid, imm_pending);
    else pass_cnt++;
    drive(1'b1, 8'h3A, 8'h08);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, ifid_imm, ifid_pc, imm_pending, fb_opcode} !==
        {1'b1, 8'hC1, 8'h3A, 8'h07, 1'b0, 4'd0})
      $display("FAIL two_byte_done: got v=%b instr=%h imm=%h pc=%h ip=%b fb=%0d required v=1 instr=c1 imm=3a pc=07 ip=0 fb=0",
               ifid_valid, ifid_instr, ifid_imm, ifid_pc, imm_pending, fb_opcode);
    else pass_cnt++;
    drive(1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_flush_imm();
    drive(1'b1, 8'hC2, 8'h09);
    step();
    total_cnt++;
    if (imm_pending !== 1'b1) $display("FAIL flush_stage: got ip=%b required 1", imm_pending);
    else pass_cnt++;
    flush = 1'b1;
    drive(1'b1, 8'h55, 8'h0A);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, imm_pending, fb_opcode} !== {1'b0, 8'h00, 1'b0, 4'd0})
      $display("FAIL flush: got v=%b instr=%h ip=%b fb=%0d required v=0 instr=00 ip=0 fb=0",
               ifid_valid, ifid_instr, imm_pending, fb_opcode);
    else pass_cnt++;
    flush = 1'b0;
    drive(1'b1, 8'h11, 8'h0A);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_imm} !== {1'b1, 8'h11, 8'h0A, 8'h00})
      $display("FAIL flush_after: got v=%b instr=%h pc=%h imm=%h required v=1 instr=11 pc=0a imm=00",
               ifid_valid, ifid_instr, ifid_pc, ifid_imm);
    else pass_cnt++;
    drive(1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_hold();
    drive(1'b1, 8'h21, 8'h0B);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h33 + i), 8'(8'h0C + i));
      step();
      total_cnt++;
      if ({ifid_valid, ifid_instr, ifid_pc, fb_opcode, fb_brx} !== {1'b1, 8'h21, 8'h0B, 4'd2, 2'd0})
        $display("FAIL hold[%0d]: got v=%b instr=%h pc=%h fb=%0d/%0d required v=1 instr=21 pc=0b fb=2/0",
                 i, ifid_valid, ifid_instr, ifid_pc, fb_opcode, fb_brx);
      else pass_cnt++;
    end
    hold = 1'b0;
    drive(1'b1, 8'h22, 8'h0C);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h22, 8'h0C})
      $display("FAIL hold_release: got v=%b instr=%h pc=%h required v=1 instr=22 pc=0c",
               ifid_valid, ifid_instr, ifid_pc);
    else pass_cnt++;
    drive(1'b0, 8'h00, 8'h00);
    step();
    total_cnt++;
    if (ifid_valid !== 1'b0) $display("FAIL hold_no_dup: got v=%b required 0", ifid_valid);
    else pass_cnt++;
  endtask

  task automatic test_int();
    flush = 1'b1; int_in = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_int} !== 2'b00)
      $display("FAIL int_flush: got v=%b int=%b required 0 0", ifid_valid, ifid_int);
    else pass_cnt++;
    flush = 1'b0; int_in = 1'b0;
    step();
    total_cnt++;
    if (ifid_int !== 1'b0) $display("FAIL int_gap: got int=%b required 0", ifid_int);
    else pass_cnt++;
    drive(1'b1, 8'h40, 8'h14);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, ifid_int} !== {1'b1, 8'h40, 1'b1})
      $display("FAIL int_tag: got v=%b instr=%h int=%b required v=1 instr=40 int=1",
               ifid_valid, ifid_instr, ifid_int);
    else pass_cnt++;
    drive(1'b1, 8'h41, 8'h15);
    step();
    total_cnt++;
    if ({ifid_instr, ifid_int} !== {8'h41, 1'b0})
      $display("FAIL int_once: got instr=%h int=%b required instr=41 int=0", ifid_instr, ifid_int);
    else pass_cnt++;
    int_in = 1'b1;
    drive(1'b1, 8'h50, 8'h16);
    step();
    total_cnt++;
    if ({ifid_valid, ifid_instr, ifid_int} !== {1'b1, 8'h50, 1'b1})
      $display("FAIL int_direct: got v=%b instr=%h int=%b required v=1 instr=50 int=1",
               ifid_valid, ifid_instr, ifid_int);
    else pass_cnt++;
    int_in = 1'b0;
    drive(1'b1, 8'h60, 8'h17);
    step();
    total_cnt++;
    if ({ifid_instr, ifid_int} !== {8'h60, 1'b0})
      $display("FAIL int_direct_clear: got instr=%h int=%b required instr=60 int=0", ifid_instr, ifid_int);
    else pass_cnt++;
    drive(1'b0, 8'h00, 8'h00);
    step();
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_flush_imm();
    test_hold();
    test_int();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
